adder12_acc_ctrl: RTL and testbench
===================================

// Module: adder12_acc_ctrl
// PURPOSE
//   Sequential accumulator controller wrapped around the combinational 12-bit cascaded
//   full-adder (a[11:0] + b[11:0] -> sum[12:0], carry-in fixed 0).
//   Drives the adder operands and consumes its 13-bit sum to accumulate a burst of
//   N input samples through a valid/ready handshake.
//   Reports the 12-bit result plus a sticky carry-out (overflow) flag.
// PARAMETERS
//   DW    12  operand width; must equal the adder's operand width (sum is DW+1)
//   CNT_W 8   width of the sample-count field; max burst length = 2**CNT_W-1
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous, active-low reset
//   start        in   1       pulse in IDLE: begin a burst of num_samples additions
//   num_samples  in   CNT_W   burst length, sampled only on accepted start
//   in_valid     in   1       in_data is valid
//   in_data      in   DW      sample to add
//   in_ready     out  1       block accepts in_data this cycle
//   add_a        out  DW      adder operand a = accumulator register
//   add_b        out  DW      adder operand b = in_data (pass-through)
//   add_sum      in   DW+1    adder result; [DW] is carry-out
//   acc_out      out  DW      accumulator value
//   ovf          out  1       sticky: some accepted add in the burst produced carry-out
//   busy         out  1       FSM not in IDLE
//   done         out  1       one-cycle pulse: burst complete, acc_out/ovf final
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, acc=0, cnt=0, len=0, ovf=0, in_ready=0,
//     done=0, busy=0. add_a=0. Takes effect immediately, including mid-burst.
//     Partial sums are discarded.
//   Datapath: add_a=acc, add_b=in_data, both combinational; the adder is combinational.
//     add_sum is therefore valid in the same cycle. No carry-in: acc is not pre-added.
//   FSM states: IDLE, ACCUM, DONE.
//   IDLE:
//     in_ready=0, busy=0.
//     On start=1: len<=num_samples, cnt<=0, acc<=0, ovf<=0.
//     If num_samples==0, go to DONE. Otherwise go to ACCUM.
//   ACCUM:
//     in_ready=1, busy=1. start is ignored.
//     Transfer = in_valid & in_ready. Each transfer, at the clock edge:
//       acc <= add_sum[DW-1:0]
//       ovf <= ovf | add_sum[DW]
//       cnt <= cnt+1
//     When a transfer occurs and cnt==len-1, go to DONE.
//     in_valid=0 holds all state; there is no timeout.
//   DONE:
//     done=1 and busy=1 for exactly one cycle. in_ready=0. Go to IDLE.
//     start asserted in DONE is ignored; it must be re-presented in IDLE.
//   acc_out and ovf hold their final values in IDLE until the next accepted start clears them.
//   Wrap-around: acc wraps modulo 2**DW; the lost carry is recorded only in ovf.
//   Total latency: start edge -> first in_ready = 1 cycle.
//     Last transfer -> done = 1 cycle.
//     Minimum burst (N samples, in_valid held high) = N+2 cycles start-to-done.
// TESTING
//   1. Reset mid-ACCUM (after 2 of 4 samples): acc_out=0, ovf=0, busy=0, in_ready=0
//      immediately, asynchronous to clk.
//   2. start, N=3, samples 1,2,3 back-to-back: acc_out=6, ovf=0, done pulses 1 cycle
//      after the 3rd transfer.
//   3. N=2, samples 0xFFF, 0x002: acc_out=0x001, ovf=1.
//      ovf persists in IDLE and clears on the next start.
//   4. N=0: done pulses 2 cycles after start, acc_out=0, in_ready never asserted.
//   5. N=4 with in_valid gaps (pattern 1,0,0,1,1,0,1): only 4 transfers counted;
//      acc = sum of the valid samples; start pulses during ACCUM and DONE have no effect.
//   6. Random N in 1..255 with random samples vs. a reference model:
//      acc_out = sum mod 4096; ovf = (any partial sum >= 4096).

Source files
------------

// File: rtl/adder12_acc_ctrl.sv
// Burst accumulator driving an external combinational DW-bit adder; one transfer per cycle while in ACCUM.
// in_ready is high only in ACCUM (start->first ready 1 cycle); in_valid low stalls with all state held, done 1 cycle after last transfer.
module adder12_acc_ctrl #(
   parameter int DW    = 12,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   input  logic [DW-1:0]    in_data,
   output logic             in_ready,
   output logic [DW-1:0]    add_a,
   output logic [DW-1:0]    add_b,
   input  logic [DW:0]      add_sum,
   output logic [DW-1:0]    acc_out,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DW-1:0]    r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_len;
   logic             r_ovf;
   logic             w_xfer;
   logic             w_last;

   assign add_a   = r_acc;
   assign add_b   = in_data;
   assign acc_out = r_acc;
   assign ovf     = r_ovf;

   assign w_xfer = in_valid && (r_state == S_ACCUM);
   assign w_last = (r_cnt == (r_len - CNT_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (num_samples == '0) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (w_xfer && w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // The carry out of the adder is the only trace of wrap-around, so it is kept sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_len <= '0;
         r_ovf <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_len <= num_samples;
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
         end else if (w_xfer) begin
            r_acc <= add_sum[DW-1:0];
            r_ovf <= r_ovf | add_sum[DW];
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_adder12_acc_ctrl.sv
// Scoreboard bench for adder12_acc_ctrl: bursts are modelled as plain sums, results checked on done.
module tb_adder12_acc_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  num_samples;
   logic        in_valid;
   logic [11:0] in_data;
   logic        in_ready;
   logic [11:0] add_a;
   logic [11:0] add_b;
   logic [12:0] add_sum;
   logic [11:0] acc_out;
   logic        ovf;
   logic        busy;
   logic        done;

   typedef struct {
      int acc;
      int ovf;
      int cyc;
   } exp_t;

   exp_t        sb[$];
   logic [11:0] samp[$];
   bit          vpat[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   adder12_acc_ctrl #(.DW(12), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .acc_out(acc_out), .ovf(ovf), .busy(busy), .done(done)
   );

   // The external 12-bit adder with carry-in fixed at zero.
   assign add_sum = {1'b0, add_a} + {1'b0, add_b};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: consumes one expectation per done pulse; a missed done also counts as a failure.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("acc_out", int'(acc_out), e.acc);
            chk("ovf", int'(ovf), e.ovf);
            chk("done_cycle", cyc, e.cyc);
            chk("busy_in_done", int'(busy), 1);
            chk("ready_in_done", int'(in_ready), 0);
         end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk("done_missing", cyc, e.cyc);
      end
   end

   // One burst: n samples from samp, valid pattern from vpat or random gaps; noise adds ignored start pulses.
   task automatic run_burst(input int n, input bit use_pat, input int gap_pct, input bit noise);
      bit   vl[$];
      int   k;
      int   total;
      int   s;
      exp_t e;
      vl = {};
      if (use_pat) begin
         vl = vpat;
      end else begin
         k = 0;
         while (k < n) begin
            bit v;
            v = ($urandom_range(99) >= gap_pct);
            vl.push_back(v);
            if (v) k++;
         end
      end
      total = 0;
      for (int i = 0; i < n; i++) total += int'(samp[i]);

      @(posedge clk); #1;
      start       = 1'b1;
      num_samples = 8'(n);
      s           = cyc;
      e.acc = total % 4096;
      e.ovf = (total >= 4096) ? 1 : 0;
      e.cyc = s + vl.size() + 1;
      sb.push_back(e);

      @(posedge clk); #1;
      start = 1'b0;
      if (n > 0) begin
         chk("ready_after_start", int'(in_ready), 1);
         chk("acc_cleared", int'(acc_out), 0);
         chk("ovf_cleared", int'(ovf), 0);
      end
      k = 0;
      for (int i = 0; i < vl.size(); i++) begin
         in_valid = vl[i];
         in_data  = vl[i] ? samp[k] : 12'($urandom);
         if (vl[i]) k++;
         start       = noise && !vl[i];
         num_samples = start ? 8'd7 : 8'(n);
         @(posedge clk); #1;
      end
      in_valid    = 1'b0;
      start       = noise;
      num_samples = 8'd5;
      chk("ready_low_done", int'(in_ready), 0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("idle_busy", int'(busy), 0);
      chk("idle_ready", int'(in_ready), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      num_samples = '0;
      in_valid    = 1'b0;
      in_data     = '0;
      #2;
      chk("rst_acc", int'(acc_out), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(in_ready), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_add_a", int'(add_a), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of a 4-sample burst after two overflowing samples.
      @(posedge clk); #1;
      start = 1'b1; num_samples = 8'd4;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_data = 12'hFFF;
      @(posedge clk); #1;
      in_data = 12'hFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mid_acc", int'(acc_out), 12'hFFE);
      chk("mid_ovf", int'(ovf), 1);
      chk("mid_busy", int'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_acc", int'(acc_out), 0);
      chk("arst_ovf", int'(ovf), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_ready", int'(in_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1+2+3 back-to-back.
      samp = {12'd1, 12'd2, 12'd3};
      run_burst(3, 1'b0, 0, 1'b0);

      // Wrap-around with sticky overflow that persists in IDLE.
      samp = {12'hFFF, 12'h002};
      run_burst(2, 1'b0, 0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("ovf_held_idle", int'(ovf), 1);
      chk("acc_held_idle", int'(acc_out), 1);

      // Empty burst.
      samp = {};
      run_burst(0, 1'b0, 0, 1'b0);

      // Gapped valid pattern with stray start pulses during ACCUM and DONE.
      samp = {12'd100, 12'd2000, 12'd1500, 12'd700};
      vpat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      run_burst(4, 1'b1, 0, 1'b1);

      // Single small sample, then random bursts.
      samp = {12'd9};
      run_burst(1, 1'b0, 0, 1'b0);
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(255, 1);
         samp = {};
         for (int i = 0; i < n; i++) samp.push_back(12'($urandom));
         run_burst(n, 1'b0, 20, r[0]);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
